// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared definitions for the main-memory arbiter: arbiter state encoding,
// block geometry and the address slices that split a byte address into
// block number and word offset.
package mem_arbiter_pkg;

    localparam int BLOCK_WORDS = 8;   // words per cache block
    localparam int WORD_W      = 3;   // width of a word offset within a block
    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 16;

    // Address slices: [BLK_HI:BLK_LO] is the block number,
    // [WORD_HI:WORD_LO] the word offset, bit 0 the byte within a word.
    localparam int BLK_HI  = 15;
    localparam int BLK_LO  = 4;
    localparam int WORD_HI = 3;
    localparam int WORD_LO = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        I_FILL  = 2'd1,
        D_FILL  = 2'd2,
        D_WRITE = 2'd3
    } state_t;

    // Word-aligned address of word 'word' inside the block containing 'base'.
    function automatic logic [ADDR_W-1:0] fill_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [WORD_W-1:0] word);
        return {base[BLK_HI:BLK_LO], word, 1'b0};
    endfunction

endpackage

// File: rtl/mem_arbiter_fill_counter.sv
// mem_arbiter_fill_counter
// 3-bit up-counter used to step through the words of a block fill.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   en       : advance by one (wraps 7 -> 0)
//   clr      : synchronous clear, has priority over en
//   count    : current word index
//   tc       : terminal count, high while count is the last word of a block
module mem_arbiter_fill_counter
    import mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    output logic [WORD_W-1:0] count,
    output logic              tc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == WORD_W'(BLOCK_WORDS - 1));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Owns the single main-memory port and shares it between the I-cache and
// D-cache. Sequences eight-word block fills (pipelined reads, one issue per
// cycle) and single-word D-side write-throughs, and steers returning read
// data to the cache that owns the current fill.
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   i_req, i_addr                  : I-cache fill request (level) and miss address
//   d_req, d_wr, d_addr, d_wdata   : D-cache request (level), write select, address, data
//   i_grant, d_grant               : requester owns memory for the current transaction
//   i_data_valid, d_data_valid     : fill data for that side is on fill_data
//   fill_word, fill_data           : word index and data of the current return
//   i_done, d_done                 : one-cycle completion pulse
//   mem_en, mem_wr, mem_addr, mem_wdata : memory request port
//   mem_data_valid, mem_rdata      : memory read return
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              i_grant,
    output logic              d_grant,
    output logic              i_data_valid,
    output logic              d_data_valid,
    output logic [WORD_W-1:0] fill_word,
    output logic [DATA_W-1:0] fill_data,
    output logic              i_done,
    output logic              d_done,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_data_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            state_reg, state_next;
    logic              last_d_reg;      // 1 when D was granted most recently
    logic              mask_i_reg;      // side just served, masked for one IDLE cycle
    logic              mask_d_reg;
    logic              issued_all_reg;  // all eight reads of this fill issued
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;

    logic              grant_i_next, grant_d_next;
    logic              i_eff, d_eff;
    logic              in_fill, issue_active, ret_en, fill_last;
    logic [WORD_W-1:0] k, r;
    logic              k_tc, r_tc;

    assign i_eff        = i_req && !mask_i_reg;
    assign d_eff        = d_req && !mask_d_reg;
    assign in_fill      = (state_reg == I_FILL) || (state_reg == D_FILL);
    assign issue_active = in_fill && !issued_all_reg;
    assign ret_en       = in_fill && mem_data_valid;
    assign fill_last    = ret_en && r_tc;

    // Both counters wrap back to 0 on their eighth step, so holding them
    // cleared outside a fill is all the housekeeping they need.
    mem_arbiter_fill_counter u_issue_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (issue_active),
        .clr   (!in_fill),
        .count (k),
        .tc    (k_tc)
    );

    mem_arbiter_fill_counter u_return_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (ret_en),
        .clr   (!in_fill),
        .count (r),
        .tc    (r_tc)
    );

    always_comb begin
        state_next   = state_reg;
        grant_i_next = 1'b0;
        grant_d_next = 1'b0;
        i_grant      = 1'b0;
        d_grant      = 1'b0;
        i_data_valid = 1'b0;
        d_data_valid = 1'b0;
        i_done       = 1'b0;
        d_done       = 1'b0;
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        fill_word    = r;
        fill_data    = '0;

        case (state_reg)
            IDLE: begin
                // On a tie the side that did not win last time goes next.
                if (i_eff && d_eff) begin
                    if (last_d_reg) grant_i_next = 1'b1;
                    else            grant_d_next = 1'b1;
                end else if (i_eff) begin
                    grant_i_next = 1'b1;
                end else if (d_eff) begin
                    grant_d_next = 1'b1;
                end
                if (grant_i_next)      state_next = I_FILL;
                else if (grant_d_next) state_next = d_wr ? D_WRITE : D_FILL;
            end
            I_FILL, D_FILL: begin
                i_grant      = (state_reg == I_FILL);
                d_grant      = (state_reg == D_FILL);
                i_data_valid = ret_en && (state_reg == I_FILL);
                d_data_valid = ret_en && (state_reg == D_FILL);
                i_done       = fill_last && (state_reg == I_FILL);
                d_done       = fill_last && (state_reg == D_FILL);
                fill_data    = ret_en ? mem_rdata : '0;
                mem_en       = issue_active;
                mem_addr     = issue_active ? fill_addr(addr_reg, k) : '0;
                if (fill_last) state_next = IDLE;
            end
            D_WRITE: begin
                d_grant    = 1'b1;
                d_done     = 1'b1;
                mem_en     = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = addr_reg;
                mem_wdata  = wdata_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_d_reg     <= 1'b0;
            mask_i_reg     <= 1'b0;
            mask_d_reg     <= 1'b0;
            issued_all_reg <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
        end else begin
            state_reg  <= state_next;
            mask_i_reg <= i_done;
            mask_d_reg <= d_done;

            if (!in_fill)                  issued_all_reg <= 1'b0;
            else if (issue_active && k_tc) issued_all_reg <= 1'b1;

            // Address and data are frozen at grant so later input changes
            // cannot disturb a transaction in progress.
            if (grant_i_next) begin
                addr_reg   <= i_addr;
                last_d_reg <= 1'b0;
            end else if (grant_d_next) begin
                addr_reg   <= d_addr;
                wdata_reg  <= d_wdata;
                last_d_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter with a pipelined memory model (fixed read
// latency) and a transaction-level reference model checked every cycle.
module tb_mem_arbiter;

    localparam int MEM_LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [15:0] i_addr = 16'h0;
    logic        d_req = 1'b0;
    logic        d_wr = 1'b0;
    logic [15:0] d_addr = 16'h0;
    logic [15:0] d_wdata = 16'h0;
    logic        i_grant, d_grant, i_data_valid, d_data_valid;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;
    logic        i_done, d_done, mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_data_valid = 1'b0;
    logic [15:0] mem_rdata = 16'h0;

    mem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .i_req          (i_req),
        .i_addr         (i_addr),
        .d_req          (d_req),
        .d_wr           (d_wr),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .i_grant        (i_grant),
        .d_grant        (d_grant),
        .i_data_valid   (i_data_valid),
        .d_data_valid   (d_data_valid),
        .fill_word      (fill_word),
        .fill_data      (fill_data),
        .i_done         (i_done),
        .d_done         (d_done),
        .mem_en         (mem_en),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_data_valid (mem_data_valid),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // ---------------- memory model ----------------
    typedef struct {
        int          t;
        logic [15:0] a;
    } rd_t;
    rd_t pend[$];
    bit stray = 1'b0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    always @(posedge clk) begin
        #2;
        mem_data_valid = 1'b0;
        mem_rdata      = 16'h0;
        if (pend.size() > 0 && pend[0].t == cyc) begin
            mem_data_valid = 1'b1;
            mem_rdata      = mem_word(pend[0].a);
            void'(pend.pop_front());
        end
        if (stray) begin
            mem_data_valid = 1'b1;
            mem_rdata      = 16'hDEAD;
        end
    end

    // ---------------- reference model + logs ----------------
    bit          m_busy = 0, m_side = 0, m_wr = 0, m_last_d = 0, m_mask_i = 0, m_mask_d = 0;
    logic [15:0] m_base = 0, m_wdata = 0;
    int          m_t = 0, m_ret = 0;

    logic [15:0] addr_log[$];
    logic [15:0] wr_addr_log[$];
    logic [15:0] wr_data_log[$];
    int          word_log[$];
    int          done_cyc[$];
    bit          done_side[$];
    int          first_en_cyc = -1;

    task automatic clear_logs();
        addr_log.delete(); wr_addr_log.delete(); wr_data_log.delete();
        word_log.delete(); done_cyc.delete(); done_side.delete();
        first_en_cyc = -1;
    endtask

    task automatic check_outputs(input bit ig, input bit dg, input bit idv, input bit ddv,
                                 input int fw, input logic [15:0] fd, input bit id, input bit dd,
                                 input bit en, input bit wr, input logic [15:0] ad,
                                 input logic [15:0] wd);
        check("i_grant", 32'(i_grant), 32'(ig));
        check("d_grant", 32'(d_grant), 32'(dg));
        check("i_data_valid", 32'(i_data_valid), 32'(idv));
        check("d_data_valid", 32'(d_data_valid), 32'(ddv));
        check("fill_word", 32'(fill_word), 32'(fw));
        check("fill_data", 32'(fill_data), 32'(fd));
        check("i_done", 32'(i_done), 32'(id));
        check("d_done", 32'(d_done), 32'(dd));
        check("mem_en", 32'(mem_en), 32'(en));
        check("mem_wr", 32'(mem_wr), 32'(wr));
        check("mem_addr", 32'(mem_addr), 32'(ad));
        check("mem_wdata", 32'(mem_wdata), 32'(wd));
    endtask

    always @(negedge clk) begin
        bit          e_fill, e_wrc, e_issue, e_dv, e_fdone, ie, de;
        logic [15:0] e_addr;
        if (rst) begin
            check_outputs(0, 0, 0, 0, 0, 16'h0, 0, 0, 0, 0, 16'h0, 16'h0);
            m_busy = 0; m_t = 0; m_ret = 0; m_last_d = 0; m_mask_i = 0; m_mask_d = 0;
        end else begin
            e_fill  = m_busy && !m_wr;
            e_wrc   = m_busy && m_wr;
            e_issue = e_fill && (m_t < 8);
            e_dv    = e_fill && mem_data_valid;
            e_fdone = e_dv && (m_ret == 7);
            e_addr  = e_issue ? ({m_base[15:4], 4'h0} + 16'(2 * m_t)) : (e_wrc ? m_base : 16'h0);
            check_outputs(m_busy && !m_side, m_busy && m_side, e_dv && !m_side, e_dv && m_side,
                          m_ret, e_dv ? mem_rdata : 16'h0, e_fdone && !m_side,
                          (e_fdone && m_side) || e_wrc, e_issue || e_wrc, e_wrc, e_addr,
                          e_wrc ? m_wdata : 16'h0);

            // logs of what the DUT actually did, for the literal checks
            if (mem_en && !mem_wr) begin
                pend.push_back('{cyc + MEM_LAT, mem_addr});
                addr_log.push_back(mem_addr);
            end
            if (mem_en && first_en_cyc < 0) first_en_cyc = cyc;
            if (mem_en && mem_wr) begin
                wr_addr_log.push_back(mem_addr);
                wr_data_log.push_back(mem_wdata);
            end
            if (i_data_valid || d_data_valid) word_log.push_back(int'(fill_word));
            if (i_done || d_done) begin
                done_cyc.push_back(cyc);
                done_side.push_back(d_done);
            end

            // advance the model to the next cycle
            if (m_busy) begin
                if (e_fdone || e_wrc) begin
                    m_busy = 0; m_ret = 0;
                    m_mask_i = !m_side; m_mask_d = m_side;
                end else begin
                    m_mask_i = 0; m_mask_d = 0;
                    m_t++;
                    if (e_dv) m_ret++;
                end
            end else begin
                ie = i_req && !m_mask_i;
                de = d_req && !m_mask_d;
                m_mask_i = 0; m_mask_d = 0;
                if (ie || de) begin
                    m_side   = (ie && de) ? !m_last_d : de;
                    m_busy   = 1;
                    m_wr     = m_side ? d_wr : 1'b0;
                    m_base   = m_side ? d_addr : i_addr;
                    m_wdata  = d_wdata;
                    m_t      = 0;
                    m_ret    = 0;
                    m_last_d = m_side;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_done(input int limit);
        bit got = 0;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (i_done || d_done) begin
                got = 1;
                break;
            end
        end
        if (!got) check("done_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int c0;
        int cnt;
        repeat (3) @(posedge clk);
        #1;
        check("reset_mem_en", 32'(mem_en), 32'd0);
        check("reset_grants", 32'({i_grant, d_grant}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // I fill
        clear_logs();
        c0 = cyc;
        i_req = 1'b1; i_addr = 16'h1236;
        wait_done(40);
        i_req = 1'b0;
        check("ifill_first_en_latency", 32'(first_en_cyc - c0), 32'd1);
        check("ifill_done_cycle", 32'(done_cyc.size() > 0 ? done_cyc[0] - first_en_cyc : -1), 32'd11);
        check("ifill_n_issue", 32'(addr_log.size()), 32'd8);
        check("ifill_addr0", 32'(addr_log.size() > 0 ? addr_log[0] : 16'h0), 32'h1230);
        check("ifill_addr7", 32'(addr_log.size() > 7 ? addr_log[7] : 16'h0), 32'h123E);
        check("ifill_n_words", 32'(word_log.size()), 32'd8);
        check("ifill_word7", 32'(word_log.size() > 7 ? word_log[7] : -1), 32'd7);
        check("ifill_done_side", 32'(done_side.size() > 0 ? done_side[0] : 1'b1), 32'd0);
        repeat (2) @(posedge clk);
        #1;

        // D write
        clear_logs();
        c0 = cyc;
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h00A4; d_wdata = 16'hBEEF;
        wait_done(10);
        d_req = 1'b0; d_wr = 1'b0;
        check("dwr_done_cycle", 32'(done_cyc.size() > 0 ? done_cyc[0] - c0 : -1), 32'd1);
        check("dwr_en_cycle", 32'(first_en_cyc - c0), 32'd1);
        check("dwr_addr", 32'(wr_addr_log.size() > 0 ? wr_addr_log[0] : 16'h0), 32'h00A4);
        check("dwr_data", 32'(wr_data_log.size() > 0 ? wr_data_log[0] : 16'h0), 32'hBEEF);
        check("dwr_count", 32'(wr_addr_log.size()), 32'd1);
        repeat (2) @(posedge clk);
        #1;

        // Tie after reset: D first, then I
        do_reset();
        clear_logs();
        i_req = 1'b1; i_addr = 16'h4000;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h8010;
        wait_done(40);
        wait_done(40);
        i_req = 1'b0; d_req = 1'b0;
        check("tie_first_side", 32'(done_side.size() > 0 ? done_side[0] : 1'b0), 32'd1);
        check("tie_second_side", 32'(done_side.size() > 1 ? done_side[1] : 1'b1), 32'd0);
        check("tie_gap", 32'(done_cyc.size() > 1 ? done_cyc[1] - done_cyc[0] : -1), 32'd13);
        check("tie_n_words", 32'(word_log.size()), 32'd16);
        check("tie_first_addr", 32'(addr_log.size() > 0 ? addr_log[0] : 16'h0), 32'h8010);
        repeat (3) @(posedge clk);
        #1;

        // Reset mid-fill after the 5th return
        i_req = 1'b1; i_addr = 16'h2000;
        cnt = 0;
        for (int n = 0; n < 40 && cnt < 5; n++) begin
            @(negedge clk);
            if (i_data_valid) cnt++;
        end
        check("rstmid_returns_seen", 32'(cnt), 32'd5);
        @(posedge clk); #1;
        rst = 1'b1; i_req = 1'b0;
        #2;
        check("rstmid_grant", 32'(i_grant), 32'd0);
        check("rstmid_en", 32'(mem_en), 32'd0);
        check("rstmid_dv", 32'(i_data_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_logs();
        repeat (8) @(posedge clk);
        #1;
        check("rstmid_no_done", 32'(done_cyc.size()), 32'd0);
        check("rstmid_no_dv", 32'(word_log.size()), 32'd0);

        // Stray data while idle
        clear_logs();
        stray = 1'b1;
        @(posedge clk); #1;
        stray = 1'b0;
        @(posedge clk); #1;
        check("stray_no_dv", 32'(word_log.size()), 32'd0);

        // Address stability: i_addr changes mid-fill
        clear_logs();
        i_req = 1'b1; i_addr = 16'h3456;
        repeat (3) @(posedge clk);
        #1;
        i_addr = 16'hFFFF;
        wait_done(40);
        i_req = 1'b0;
        check("stab_n_issue", 32'(addr_log.size()), 32'd8);
        check("stab_addr3", 32'(addr_log.size() > 3 ? addr_log[3] : 16'h0), 32'h3456);
        check("stab_addr7", 32'(addr_log.size() > 7 ? addr_log[7] : 16'h0), 32'h345E);
        repeat (4) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single shared main-memory port between the I-cache and D-cache fill controllers. It sequences eight-word block fills and single-word D-side write-throughs, and routes returning read data back to the owning cache. It sits between both caches' miss logic and the multicycle memory, and is the only block that drives memory enable, write and address.

## Interface
- BLOCK_WORDS, 8: words per cache block (16-byte block, 2-byte words).
- MEM_LAT, 4: cycles from a read issue to its mem_data_valid return; memory is pipelined and accepts one read per cycle.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- i_req  in  1  I-cache fill request; level, held until i_done.
- i_addr  in  16  I-side miss address; bits [15:4] select the block.
- d_req  in  1  D-cache request; level, held until d_done.
- d_wr  in  1  1 selects a single-word write, 0 selects a block fill; sampled with d_req.
- d_addr  in  16  D-side address.
- d_wdata  in  16  D-side write data.
- i_grant, d_grant  out  1  the requester owns memory for the current transaction.
- i_data_valid, d_data_valid  out  1  fill data is on fill_data this cycle.
- fill_word  out  3  word index of the current fill_data.
- fill_data  out  16  memory read data; passed through from mem_rdata.
- i_done, d_done  out  1  one-cycle pulse when the transaction completes.
- mem_en, mem_wr  out  1  memory access strobe and write select.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  memory write data.
- mem_data_valid  in  1  read data valid from memory.
- mem_rdata  in  16  read data from memory.

## Operation
- States: IDLE, I_FILL, D_FILL, D_WRITE. The state is registered.
- Request handling in IDLE:
  - i_req only → I_FILL.
  - d_req only → D_WRITE if d_wr, else D_FILL.
  - Both requesting → grant the side not granted last. A 1-bit last-grant register resets to I, so D wins the first tie.
- Fill:
  - Issue counter k runs 0..7. mem_en=1 and mem_addr={addr[15:4],k,1'b0} for 8 consecutive cycles. mem_wr=0.
  - Return counter r runs 0..7 and increments on each mem_data_valid in a fill state. fill_word=r.
  - The owning side's *_data_valid equals mem_data_valid gated by state.
  - On the 8th return, assert *_done and go to IDLE.
- Write: D_WRITE lasts one cycle with mem_en=1, mem_wr=1, mem_addr=d_addr and mem_wdata=d_wdata. d_done=1 in that same cycle, then go to IDLE.
- Masking: in the first IDLE cycle after a done, the just-served requester's req is masked. The other side's req is not masked.
- Outputs outside their transaction: grant, data_valid and done are all 0; mem_addr and mem_wdata are 0 and mem_en is 0.
- Stray data: mem_data_valid arriving in IDLE, in D_WRITE, or after r=7 is ignored.
- Address capture: the address is captured at grant. Later changes on i_addr or d_addr do not affect an in-progress fill.

## Timing
- Reset value of every output is 0. State is IDLE, k=r=0, last-grant=I.
- Request to grant: a req sampled at edge N sets grant from cycle N+1. The first mem_en is in cycle N+1.
- Fill issue runs cycles N+1..N+8. Returns arrive at N+1+MEM_LAT..N+8+MEM_LAT. done is in the cycle of the last return, i.e. N+12 with MEM_LAT=4.
- Write: mem_en and d_done are both in cycle N+1. The state is IDLE again at N+2.
- Back-to-back transactions: the earliest next grant is 2 cycles after done (one IDLE cycle in between).
- Reset mid-transaction: everything returns to IDLE within the same cycle (asynchronous). In-flight returns after reset are ignored and no done is produced.

## Structure
- Shared package holds:
  - the state enum;
  - BLOCK_WORDS and the word-offset width (3);
  - the block-address slice constants ([15:4] and [3:1]).
- One natural sub-module, fill_counter: a 3-bit up-counter with enable, synchronous clear, and a terminal-count flag. It is instantiated twice, once for issue and once for return.

## Test plan
- **I fill:** i_req=1, i_addr=0x1236 → mem_addr 0x1230, 0x1232, … 0x123E over 8 cycles. i_data_valid with fill_word 0..7. i_done at cycle 12.
- **D write:** d_req=1, d_wr=1, d_addr=0x00A4, d_wdata=0xBEEF → one cycle of mem_en=mem_wr=1 with mem_addr=0x00A4 and mem_wdata=0xBEEF. d_done is in the same cycle.
- **Tie after reset:** both reqs raised together → D_FILL first. When D's req is held again after d_done, the second grant goes to I (mask plus last-grant).
- **Reset mid-fill:** assert rst after the 5th return → outputs 0 immediately. Late mem_data_valid pulses produce no data_valid and no done.
- **Stray data and address stability:** mem_data_valid while IDLE → no data_valid. Changing i_addr mid-fill → the issued addresses keep the original block.
